activate_stage: RTL and testbench

ACTIVATE_STAGE -- requirements
Module: activate_stage

---
 rtl/activate_stage_pkg.sv | 10 +
 rtl/activate_stage_activation_unit.sv | 35 +++
 rtl/activate_stage.sv | 87 ++++++++
 tb/tb_activate_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/activate_stage_pkg.sv
// activate_stage_pkg: activation encodings, FSM states and Q8.8 constants shared by the activate stage
package activate_stage_pkg;
    localparam int ACT_IDENT = 0;
    localparam int ACT_RELU  = 1;
    localparam int ACT_LRELU = 2;
    localparam int ACT_HSIG  = 3;
    localparam int ONE  = 'h0100;
    localparam int HALF = 'h0080;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/activate_stage_activation_unit.sv
// activation_unit: combinational single-lane activation and derivative in signed Q8.8
module activation_unit
    import activate_stage_pkg::*;
#(
    parameter int data_size     = 16,
    parameter int act_type_size = 4
) (
    input  logic signed [data_size-1:0]     y,
    input  logic        [act_type_size-1:0] act_type,
    output logic        [data_size-1:0]     a,
    output logic        [data_size-1:0]     da
);
    localparam logic signed [data_size:0] lim = (data_size+1)'(512);
    logic neg, pos, in_win;
    logic signed [data_size:0] ys, sum;
    logic signed [data_size-1:0] lr;
    logic [data_size-1:0] hs_a, one_d;
    // shifts live in their own statements so the unsigned ternaries below cannot turn them logical
    always_comb begin
        one_d  = data_size'(ONE);
        neg    = y[data_size-1];
        pos    = !neg && |y;
        lr     = y >>> 3;
        ys     = {y[data_size-1], y};
        sum    = (ys >>> 2) + (data_size+1)'(HALF);
        in_win = (ys > -lim) && (ys < lim);
        hs_a   = sum[data_size] ? '0 : (sum > (data_size+1)'(ONE)) ? one_d : sum[data_size-1:0];
        a  = (act_type == act_type_size'(ACT_RELU))  ? (neg ? '0 : y) :
             (act_type == act_type_size'(ACT_LRELU)) ? (neg ? lr : y) :
             (act_type == act_type_size'(ACT_HSIG))  ? hs_a : y;
        da = (act_type == act_type_size'(ACT_RELU))  ? (pos ? one_d : '0) :
             (act_type == act_type_size'(ACT_LRELU)) ? (neg ? data_size'(32'h20) : one_d) :
             (act_type == act_type_size'(ACT_HSIG))  ? (in_win ? data_size'(32'h40) : '0) : one_d;
    end
endmodule

// File: rtl/activate_stage.sv
// activate_stage: captures a vector, activates it one lane per cycle through a shared unit, holds result until taken
module activate_stage
    import activate_stage_pkg::*;
#(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int act_type_size          = 4,
    parameter int dense_type_size        = 4,
    parameter int cost_type_size         = 8,
    parameter int backprop_controll_size = 100
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [act_type_size-1:0]          act_type,
    input  logic [dense_type_size-1:0]        dense_type,
    input  logic [cost_type_size-1:0]         cost_type,
    input  logic [data_size*size-1:0]         w,
    input  logic [data_size*size-1:0]         y,
    input  logic [data_size*size-1:0]         x,
    input  logic [data_size*size-1:0]         predict_value,
    input  logic [backprop_controll_size-1:0] backprop_controll,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [data_size*size-1:0]         a_out,
    output logic [data_size*size-1:0]         da_out,
    output logic [dense_type_size-1:0]        dense_type_out,
    output logic [cost_type_size-1:0]         cost_type_out,
    output logic [data_size*size-1:0]         w_out,
    output logic [data_size*size-1:0]         x_out,
    output logic [data_size*size-1:0]         predict_value_out,
    output logic [backprop_controll_size-1:0] backprop_controll_out
);
    localparam int iw = $clog2(size + 1);
    state_t state;
    logic [iw-1:0] idx;
    logic [act_type_size-1:0] act_r;
    logic [data_size*size-1:0] y_r;
    logic [data_size-1:0] lane_a, lane_da;
    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    activation_unit #(.data_size(data_size), .act_type_size(act_type_size)) u_act (
        .y        (y_r[idx*data_size +: data_size]),
        .act_type (act_r),
        .a        (lane_a),
        .da       (lane_da)
    );
    // idx runs one past the last lane so out_valid lands size+1 cycles after accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= ST_IDLE;
            idx                   <= '0;
            act_r                 <= '0;
            y_r                   <= '0;
            a_out                 <= '0;
            da_out                <= '0;
            dense_type_out        <= '0;
            cost_type_out         <= '0;
            w_out                 <= '0;
            x_out                 <= '0;
            predict_value_out     <= '0;
            backprop_controll_out <= '0;
        end else if (in_ready && in_valid) begin
            state                 <= ST_RUN;
            idx                   <= '0;
            act_r                 <= act_type;
            y_r                   <= y;
            dense_type_out        <= dense_type;
            cost_type_out         <= cost_type;
            w_out                 <= w;
            x_out                 <= x;
            predict_value_out     <= predict_value;
            backprop_controll_out <= backprop_controll;
        end else if (state == ST_RUN) begin
            if (idx == iw'(size)) begin
                state <= ST_DONE;
            end else begin
                a_out[idx*data_size +: data_size]  <= lane_a;
                da_out[idx*data_size +: data_size] <= lane_da;
                idx <= idx + 1'b1;
            end
        end else if (out_valid && out_ready) begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_activate_stage.sv
// tb_activate_stage: directed and randomized vectors checked against an integer activation model
module tb_activate_stage;
    localparam int S = 3, DW = 16, AW = 4, TW = 4, CW = 8, BW = 100, VW = S*DW;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, in_ready, out_valid;
    logic [AW-1:0] act_type = '0;
    logic [TW-1:0] dense_type = '0, dense_type_out;
    logic [CW-1:0] cost_type = '0, cost_type_out;
    logic [VW-1:0] w = '0, y = '0, x = '0, predict_value = '0;
    logic [VW-1:0] a_out, da_out, w_out, x_out, predict_value_out;
    logic [BW-1:0] backprop_controll = '0, backprop_controll_out;
    logic [TW-1:0] e_t;
    logic [CW-1:0] e_c;
    logic [VW-1:0] e_w, e_x, e_p;
    logic [BW-1:0] e_b;
    int tests = 0, fails = 0;

    activate_stage #(.size(S), .data_size(DW), .act_type_size(AW), .dense_type_size(TW),
                     .cost_type_size(CW), .backprop_controll_size(BW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .act_type(act_type), .dense_type(dense_type), .cost_type(cost_type),
        .w(w), .y(y), .x(x), .predict_value(predict_value), .backprop_controll(backprop_controll),
        .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out), .da_out(da_out),
        .dense_type_out(dense_type_out), .cost_type_out(cost_type_out), .w_out(w_out),
        .x_out(x_out), .predict_value_out(predict_value_out),
        .backprop_controll_out(backprop_controll_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] act_model(input logic [AW-1:0] t, input logic [DW-1:0] yl);
        int v, av, dv;
        v = int'($signed(yl));
        case (t)
            4'd1: begin av = v < 0 ? 0 : v; dv = v > 0 ? 256 : 0; end
            4'd2: begin av = v < 0 ? v >>> 3 : v; dv = v < 0 ? 32 : 256; end
            4'd3: begin
                av = (v >>> 2) + 128;
                av = av < 0 ? 0 : (av > 256 ? 256 : av);
                dv = (v > -512 && v < 512) ? 64 : 0;
            end
            default: begin av = v; dv = 256; end
        endcase
        return {16'(dv), 16'(av)};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        logic [DW-1:0] edges [8];
        edges = '{16'h0000, 16'h0200, 16'hFE00, 16'h01FF, 16'hFE01, 16'h8000, 16'h7FFF, 16'hFFFF};
        for (int i = 0; i < S; i++)
            case ($urandom_range(0, 2))
                0: r[i*DW +: DW] = 16'($urandom);
                1: r[i*DW +: DW] = 16'($urandom_range(0, 1535)) - 16'd768;
                default: r[i*DW +: DW] = edges[$urandom_range(0, 7)];
            endcase
        return r;
    endfunction

    task automatic load_inputs(input logic [AW-1:0] t, input logic [VW-1:0] yv);
        act_type = t;
        y = yv;
        dense_type = TW'($urandom);
        cost_type = CW'($urandom);
        w = VW'({$urandom, $urandom});
        x = VW'({$urandom, $urandom});
        predict_value = VW'({$urandom, $urandom});
        backprop_controll = BW'({$urandom, $urandom, $urandom, $urandom});
        e_t = dense_type; e_c = cost_type; e_w = w; e_x = x; e_p = predict_value; e_b = backprop_controll;
    endtask

    task automatic run_vec(input logic [AW-1:0] t, input logic [VW-1:0] yv, input bit fix,
                           input logic [VW-1:0] fa, input logic [VW-1:0] fd, input int hold);
        logic [VW-1:0] ea, ed;
        int cyc;
        for (int i = 0; i < S; i++)
            {ed[i*DW +: DW], ea[i*DW +: DW]} = act_model(t, yv[i*DW +: DW]);
        if (fix) begin ea = fa; ed = fd; end
        @(negedge clk);
        load_inputs(t, yv);
        in_valid = 1;
        check("in_ready_idle", 128'(in_ready), 128'(1'b1));
        @(posedge clk); #1;
        in_valid = 0;
        act_type = AW'($urandom);
        y = rand_vec();
        w = VW'({$urandom, $urandom});
        backprop_controll = ~backprop_controll;
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check("latency", 128'(cyc), 128'(S + 1));
        check("a_out", 128'(a_out), 128'(ea));
        check("da_out", 128'(da_out), 128'(ed));
        check("in_ready_done", 128'(in_ready), 128'(1'b0));
        check("dense_type_out", 128'(dense_type_out), 128'(e_t));
        check("cost_type_out", 128'(cost_type_out), 128'(e_c));
        check("w_out", 128'(w_out), 128'(e_w));
        check("x_out", 128'(x_out), 128'(e_x));
        check("predict_value_out", 128'(predict_value_out), 128'(e_p));
        check("backprop_controll_out", 128'(backprop_controll_out), 128'(e_b));
        repeat (hold) begin
            in_valid = 1;
            y = rand_vec();
            act_type = AW'($urandom);
            @(posedge clk); #1;
            check("hold_out_valid", 128'(out_valid), 128'(1'b1));
            check("hold_in_ready", 128'(in_ready), 128'(1'b0));
            check("hold_a_out", 128'(a_out), 128'(ea));
            check("hold_da_out", 128'(da_out), 128'(ed));
            check("hold_w_out", 128'(w_out), 128'(e_w));
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        check("release_out_valid", 128'(out_valid), 128'(1'b0));
        check("release_in_ready", 128'(in_ready), 128'(1'b1));
        out_ready = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_a_out", 128'(a_out), 128'(0));
        check("rst_backprop", 128'(backprop_controll_out), 128'(0));
        @(negedge clk) rst_n = 1;

        run_vec(4'd1, {16'h0180, 16'h0000, 16'hFF00}, 1, {16'h0180, 16'h0000, 16'h0000},
                {16'h0100, 16'h0000, 16'h0000}, 0);
        run_vec(4'd2, {16'h8000, 16'h0100, 16'hFF00}, 1, {16'hF000, 16'h0100, 16'hFFE0},
                {16'h0020, 16'h0100, 16'h0020}, 0);
        run_vec(4'd3, {16'h0000, 16'hFD00, 16'h0300}, 1, {16'h0080, 16'h0000, 16'h0100},
                {16'h0040, 16'h0000, 16'h0000}, 0);
        run_vec(4'd0, {16'h8000, 16'h7FFF, 16'h1234}, 0, '0, '0, 5);
        run_vec(4'd9, rand_vec(), 0, '0, '0, 1);

        // reset while lane 1 is being processed
        @(negedge clk);
        load_inputs(4'd3, rand_vec());
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("midrun_rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("midrun_rst_a_out", 128'(a_out), 128'(0));
        check("midrun_rst_da_out", 128'(da_out), 128'(0));
        check("midrun_rst_w_out", 128'(w_out), 128'(0));
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < S + 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_out_valid", 128'(out_valid), 128'(1'b0));
            check("post_rst_in_ready", 128'(in_ready), 128'(1'b1));
        end
        run_vec(4'd2, rand_vec(), 0, '0, '0, 0);

        for (int k = 0; k < 30; k++)
            run_vec(AW'($urandom_range(0, 4) == 4 ? $urandom_range(4, 15) : $urandom_range(0, 3)),
                    rand_vec(), 0, '0, '0, $urandom_range(0, 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
